// File: rtl/branch_resolve_unit_if.sv
// Training-update bundle from the branch resolve unit to the fetch-stage predictor.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_info_if;
    logic                   branch_flag;
    logic                   taken;
    logic [`ADDR_WIDTH-1:0] pc;
    logic [`ADDR_WIDTH-1:0] branch_addr;

    modport o (output branch_flag, taken, pc, branch_addr);
    modport i (input  branch_flag, taken, pc, branch_addr);
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order prediction queue resolved by EX; emits predictor training and a flush/redirect on mispredict.
// Define BRU_PERF_CNT_EN to add saturating branch and mispredict counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_resolve_unit #(
    parameter int Q_DEPTH   = 4,
    parameter int Q_PTR_W   = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid,
    output logic                   pred_ready,
    input  logic [`ADDR_WIDTH-1:0] pred_pc,
    input  logic                   pred_taken,
    input  logic [`ADDR_WIDTH-1:0] pred_target,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic                   res_is_branch,
    input  logic                   res_taken,
    input  logic [`ADDR_WIDTH-1:0] res_target,
    output logic                   flush,
    output logic [`ADDR_WIDTH-1:0] redirect_pc,
    branch_info_if.o               branch_info
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]   branch_cnt,
    output logic [CNT_WIDTH-1:0]   mispredict_cnt
`endif
);

    localparam int AW = `ADDR_WIDTH;

    if (Q_DEPTH < 2 || Q_DEPTH != (1 << Q_PTR_W)) begin : g_bad_depth
        $error("Q_DEPTH must be a power of two >= 2 equal to 2**Q_PTR_W");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("CNT_WIDTH must be at least 1");
    end

    typedef enum logic {NORMAL, FLUSH} state_t;

    state_t           r_state;
    logic [Q_PTR_W:0] r_wr_ptr;
    logic [Q_PTR_W:0] r_rd_ptr;
    logic [AW-1:0]    r_q_pc     [Q_DEPTH];
    logic             r_q_taken  [Q_DEPTH];
    logic [AW-1:0]    r_q_target [Q_DEPTH];
    logic             r_flush;
    logic [AW-1:0]    r_redirect_pc;
    logic             r_bi_flag;
    logic             r_bi_taken;
    logic [AW-1:0]    r_bi_pc;
    logic [AW-1:0]    r_bi_addr;

    logic [Q_PTR_W-1:0] w_wr_idx;
    logic [Q_PTR_W-1:0] w_rd_idx;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [AW-1:0]      w_head_pc;
    logic               w_head_taken;
    logic [AW-1:0]      w_head_target;
    logic [AW-1:0]      w_seq;
    logic [AW-1:0]      w_act_next;
    logic [AW-1:0]      w_prd_next;
    logic               w_mispredict;

    assign w_wr_idx = r_wr_ptr[Q_PTR_W-1:0];
    assign w_rd_idx = r_rd_ptr[Q_PTR_W-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[Q_PTR_W] != r_rd_ptr[Q_PTR_W]) && (w_wr_idx == w_rd_idx);

    // Readies depend only on registered state, so a same-cycle pop never frees a full queue.
    assign pred_ready = !w_full  && (r_state == NORMAL);
    assign res_ready  = !w_empty && (r_state == NORMAL);
    assign w_push     = pred_valid && pred_ready;
    assign w_pop      = res_valid  && res_ready;

    assign w_head_pc     = r_q_pc[w_rd_idx];
    assign w_head_taken  = r_q_taken[w_rd_idx];
    assign w_head_target = r_q_target[w_rd_idx];
    assign w_seq         = w_head_pc + AW'(4);
    assign w_act_next    = (res_is_branch && res_taken) ? res_target : w_seq;
    assign w_prd_next    = w_head_taken ? w_head_target : w_seq;
    assign w_mispredict  = (w_act_next != w_prd_next);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[w_wr_idx]     <= pred_pc;
            r_q_taken[w_wr_idx]  <= pred_taken;
            r_q_target[w_wr_idx] <= pred_target;
        end
    end

    // A mispredict empties the queue on the same edge, dropping any concurrent push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= NORMAL;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (w_pop && w_mispredict) begin
                        r_state       <= FLUSH;
                        r_flush       <= 1'b1;
                        r_redirect_pc <= w_act_next;
                        r_wr_ptr      <= '0;
                        r_rd_ptr      <= '0;
                    end else begin
                        if (w_push) r_wr_ptr <= r_wr_ptr + (Q_PTR_W+1)'(1);
                        if (w_pop)  r_rd_ptr <= r_rd_ptr + (Q_PTR_W+1)'(1);
                    end
                end
                FLUSH: begin
                    r_state <= NORMAL;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bi_flag  <= 1'b0;
            r_bi_taken <= 1'b0;
            r_bi_pc    <= '0;
            r_bi_addr  <= '0;
        end else begin
            r_bi_flag <= w_pop && res_is_branch;
            if (w_pop && res_is_branch) begin
                r_bi_taken <= res_taken;
                r_bi_pc    <= w_head_pc;
                r_bi_addr  <= res_target;
            end
        end
    end

    assign flush                   = r_flush;
    assign redirect_pc             = r_redirect_pc;
    assign branch_info.branch_flag = r_bi_flag;
    assign branch_info.taken       = r_bi_taken;
    assign branch_info.pc          = r_bi_pc;
    assign branch_info.branch_addr = r_bi_addr;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispredict_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_pop && res_is_branch && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            if (w_pop && w_mispredict && (r_mispredict_cnt != '1))
                r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_resolve_unit;

   localparam int AW = `ADDR_WIDTH;
   localparam int QD = 4;

   typedef struct {
      logic [AW-1:0] pc;
      logic          taken;
      logic [AW-1:0] target;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          predValid;
   logic          predReady;
   logic [AW-1:0] predPc;
   logic          predTaken;
   logic [AW-1:0] predTarget;
   logic          resValid;
   logic          resReady;
   logic          resIsBranch;
   logic          resTaken;
   logic [AW-1:0] resTarget;
   logic          flush;
   logic [AW-1:0] redirectPc;
`ifdef BRU_PERF_CNT_EN
   logic [31:0]   branchCnt;
   logic [31:0]   mispredictCnt;
`endif

   branch_info_if bi();

   branch_resolve_unit #(.Q_DEPTH(QD), .Q_PTR_W(2), .CNT_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .pred_valid   (predValid),
      .pred_ready   (predReady),
      .pred_pc      (predPc),
      .pred_taken   (predTaken),
      .pred_target  (predTarget),
      .res_valid    (resValid),
      .res_ready    (resReady),
      .res_is_branch(resIsBranch),
      .res_taken    (resTaken),
      .res_target   (resTarget),
      .flush        (flush),
      .redirect_pc  (redirectPc),
      .branch_info  (bi)
`ifdef BRU_PERF_CNT_EN
      ,
      .branch_cnt    (branchCnt),
      .mispredict_cnt(mispredictCnt)
`endif
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   bit checkEn    = 1'b0;

   // Reference model: the in-flight records plus the outputs expected after each edge.
   rec_t          mq[$];
   bit            mInFlush;
   logic          eFlush;
   logic [AW-1:0] eRedirect;
   logic          eFlag;
   logic          eTaken;
   logic [AW-1:0] ePc;
   logic [AW-1:0] eAddr;
   logic [31:0]   eBrCnt;
   logic [31:0]   eMisCnt;

   function automatic logic mPredReady();
      return (mq.size() < QD) && !mInFlush;
   endfunction

   function automatic logic mResReady();
      return (mq.size() > 0) && !mInFlush;
   endfunction

   task automatic modelReset();
      mq.delete();
      mInFlush  = 1'b0;
      eFlush    = 1'b0;
      eRedirect = '0;
      eFlag     = 1'b0;
      eTaken    = 1'b0;
      ePc       = '0;
      eAddr     = '0;
      eBrCnt    = '0;
      eMisCnt   = '0;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One clock: evaluate the model on the inputs present before the edge, then advance it.
   task automatic tick();
      bit            inReset;
      bit            accPush;
      bit            accPop;
      bit            mis;
      rec_t          head;
      rec_t          rec;
      logic [AW-1:0] seqPc;
      logic [AW-1:0] actNext;
      logic [AW-1:0] prdNext;
      inReset     = !rst;
      accPush     = predValid && mPredReady();
      accPop      = resValid && mResReady();
      rec.pc      = predPc;
      rec.taken   = predTaken;
      rec.target  = predTarget;
      mis         = 1'b0;
      actNext     = '0;
      if (accPop) begin
         head    = mq[0];
         seqPc   = head.pc + 4;
         actNext = (resIsBranch && resTaken) ? resTarget : seqPc;
         prdNext = head.taken ? head.target : seqPc;
         mis     = (actNext != prdNext);
      end
      @(posedge clk);
      #1;
      if (!inReset) begin
         eFlag = accPop && resIsBranch;
         if (accPop && resIsBranch) begin
            eTaken = resTaken;
            ePc    = head.pc;
            eAddr  = resTarget;
            if (eBrCnt != 32'hFFFF_FFFF) eBrCnt++;
         end
         if (accPop && mis && eMisCnt != 32'hFFFF_FFFF) eMisCnt++;
         if (accPop && mis) begin
            mq.delete();
            mInFlush  = 1'b1;
            eFlush    = 1'b1;
            eRedirect = actNext;
         end else begin
            mInFlush = 1'b0;
            eFlush   = 1'b0;
            if (accPop) void'(mq.pop_front());
            if (accPush) mq.push_back(rec);
         end
      end
   endtask

   task automatic applyStimulus(input logic pv, input logic [AW-1:0] ppc, input logic ptk,
                                input logic [AW-1:0] ptgt, input logic rv, input logic rib,
                                input logic rtk, input logic [AW-1:0] rtgt);
      predValid   = pv;
      predPc      = ppc;
      predTaken   = ptk;
      predTarget  = ptgt;
      resValid    = rv;
      resIsBranch = rib;
      resTaken    = rtk;
      resTarget   = rtgt;
      tick();
   endtask

   task automatic idle();
      applyStimulus(0, '0, 0, '0, 0, 0, 0, '0);
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("flush",       flush,          eFlush);
         checkOutput("redirect_pc", redirectPc,     eRedirect);
         checkOutput("branch_flag", bi.branch_flag, eFlag);
         checkOutput("bi_taken",    bi.taken,       eTaken);
         checkOutput("bi_pc",       bi.pc,          ePc);
         checkOutput("bi_addr",     bi.branch_addr, eAddr);
         checkOutput("pred_ready",  predReady,      mPredReady());
         checkOutput("res_ready",   resReady,       mResReady());
`ifdef BRU_PERF_CNT_EN
         checkOutput("branch_cnt",     branchCnt,     eBrCnt);
         checkOutput("mispredict_cnt", mispredictCnt, eMisCnt);
`endif
      end
   end

   initial begin
      rst = 1'b1;
      predValid = 0; predPc = '0; predTaken = 0; predTarget = '0;
      resValid = 0; resIsBranch = 0; resTaken = 0; resTarget = '0;
      #2;
      rst = 1'b0;
      modelReset();
      checkEn = 1'b1;
      repeat (3) tick();
      checkOutput("reset_flush",      flush,          0);
      checkOutput("reset_flag",       bi.branch_flag, 0);
      checkOutput("reset_pred_ready", predReady,      1);
      checkOutput("reset_res_ready",  resReady,       0);
      rst = 1'b1;
      idle();

      $display("[TB] correct not-taken branch");
      applyStimulus(1, 32'h1C00_0000, 0, '0, 0, 0, 0, '0);
      applyStimulus(0, '0, 0, '0, 1, 1, 0, 32'h1C00_0040);
      checkOutput("nt_flag",  bi.branch_flag, 1);
      checkOutput("nt_taken", bi.taken,       0);
      checkOutput("nt_pc",    bi.pc,          32'h1C00_0000);
      checkOutput("nt_addr",  bi.branch_addr, 32'h1C00_0040);
      checkOutput("nt_flush", flush,          0);
      idle();
      checkOutput("nt_flag_drop", bi.branch_flag, 0);

      $display("[TB] taken mispredict with same-cycle push");
      applyStimulus(1, 32'h1C00_0010, 0, '0, 0, 0, 0, '0);
      applyStimulus(1, 32'h1C00_0014, 0, '0, 0, 0, 0, '0);
      applyStimulus(1, 32'h1C00_0018, 0, '0, 1, 1, 1, 32'h1C00_0100);
      checkOutput("tm_flush",      flush,      1);
      checkOutput("tm_redirect",   redirectPc, 32'h1C00_0100);
      checkOutput("tm_flag",       bi.branch_flag, 1);
      checkOutput("tm_pred_ready", predReady,  0);
      checkOutput("tm_res_ready",  resReady,   0);
      idle();
      checkOutput("tm_flush_end",   flush,     0);
      checkOutput("tm_pred_ready2", predReady, 1);
      checkOutput("tm_empty",       resReady,  0);
      applyStimulus(0, '0, 0, '0, 1, 1, 1, 32'h0000_DEAD);
      checkOutput("empty_res_flag", bi.branch_flag, 0);
      checkOutput("empty_res_pc",   bi.pc,          32'h1C00_0010);

      $display("[TB] wrong target");
      applyStimulus(1, 32'h0000_0100, 1, 32'h0000_0200, 0, 0, 0, '0);
      applyStimulus(0, '0, 0, '0, 1, 1, 1, 32'h0000_0300);
      checkOutput("wt_flush",    flush,      1);
      checkOutput("wt_redirect", redirectPc, 32'h0000_0300);
      idle();

      $display("[TB] non-branch predicted taken / not taken");
      applyStimulus(1, 32'h0000_0400, 1, 32'h0000_0800, 0, 0, 0, '0);
      applyStimulus(0, '0, 0, '0, 1, 0, 0, '0);
      checkOutput("nb_flush",    flush,          1);
      checkOutput("nb_redirect", redirectPc,     32'h0000_0404);
      checkOutput("nb_flag",     bi.branch_flag, 0);
      idle();
      applyStimulus(1, 32'h0000_0500, 0, '0, 0, 0, 0, '0);
      applyStimulus(0, '0, 0, '0, 1, 0, 0, '0);
      checkOutput("nbn_flush", flush,          0);
      checkOutput("nbn_flag",  bi.branch_flag, 0);

      $display("[TB] full queue and pointer wrap");
      for (int i = 0; i < 4; i++)
         applyStimulus(1, AW'(4 * i), 0, '0, 0, 0, 0, '0);
      checkOutput("full_pred_ready", predReady, 0);
      applyStimulus(1, 32'h10, 0, '0, 1, 1, 0, 32'h40);
      checkOutput("full_pop_pc",     bi.pc,    32'h0);
      checkOutput("full_push_block", predReady, 1);
      applyStimulus(1, 32'h10, 0, '0, 1, 1, 0, 32'h40);
      checkOutput("wrap_pop_pc", bi.pc, 32'h4);
      applyStimulus(1, 32'h14, 0, '0, 0, 0, 0, '0);
      checkOutput("wrap_full", predReady, 0);
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] wantPc;
         wantPc = AW'(32'h8 + 4 * i);
         applyStimulus(0, '0, 0, '0, 1, 1, 0, 32'h40);
         checkOutput("wrap_order_pc", bi.pc, {32'h0, wantPc});
      end
      checkOutput("wrap_drained", resReady, 0);
      idle();

`ifdef BRU_PERF_CNT_EN
      checkOutput("perf_branch_cnt",     branchCnt,     9);
      checkOutput("perf_mispredict_cnt", mispredictCnt, 3);
`endif

      $display("[TB] reset asserted during flush");
      applyStimulus(1, 32'h0000_0600, 0, '0, 0, 0, 0, '0);
      applyStimulus(0, '0, 0, '0, 1, 1, 1, 32'h0000_0700);
      checkOutput("mr_flush_before", flush, 1);
      rst = 1'b0;
      #1;
      checkOutput("mr_flush_drop", flush,          0);
      checkOutput("mr_redirect",   redirectPc,     0);
      checkOutput("mr_flag",       bi.branch_flag, 0);
      modelReset();
      repeat (2) tick();
      rst = 1'b1;
      idle();
      checkOutput("mr_pred_ready", predReady, 1);
      idle();

      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
